// File: rtl/pipe_issue_stage_if.sv
// Instruction-issue bus: upstream valid/ready word input plus the decoded
// issue slot and buffer occupancy presented to the pipeline.
//   master : instruction source / pipeline side (drives in_valid, in_instr)
//   slave  : pipe_issue_stage (drives in_ready, issue fields, fifo_count)
interface pipe_issue_stage_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             issue_valid;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [3:0]       func;
  logic [31:0]      addr;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output in_valid, in_instr,
    input  in_ready, issue_valid, rs1, rs2, rd, func, addr, fifo_count
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, issue_valid, rs1, rs2, rd, func, addr, fifo_count
  );
endinterface

// File: rtl/pipe_issue_stage.sv
// pipe_issue_stage: buffers 32-bit instruction words in a FIFO, decodes the
// head into rs1/rs2/rd/func/addr and issues it unless a source register is
// still in flight (tracked by a HAZARD_WINDOW-deep rd scoreboard).
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : pipe_issue_stage_if.slave (in_valid/in_ready/in_instr in,
//            issue_valid/rs1/rs2/rd/func/addr/fifo_count out)
//   perf_issued, perf_bubbles : present only when ISSUE_PERF_CNT_EN is defined
// Optional feature macro: ISSUE_PERF_CNT_EN (issue / hazard-bubble counters).
module pipe_issue_stage #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned HAZARD_WINDOW = 3,
  parameter logic [31:0] ADDR_BASE     = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0] perf_issued,
  output logic [31:0] perf_bubbles,
`endif
  pipe_issue_stage_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic          hazard;
  logic          not_empty;
  logic          in_ready_c;

  logic [31:0]   head;
  logic [3:0]    head_func;
  logic [4:0]    head_rd;
  logic [4:0]    head_rs1;
  logic [4:0]    head_rs2;
  logic [12:0]   head_imm;

  logic          sb_valid [HAZARD_WINDOW];
  logic [4:0]    sb_rd    [HAZARD_WINDOW];

  logic          issue_valid_q;
  logic [4:0]    rs1_q;
  logic [4:0]    rs2_q;
  logic [4:0]    rd_q;
  logic [3:0]    func_q;
  logic [31:0]   addr_q;

  // Head decode
  assign head      = mem[rd_ptr];
  assign head_func = head[31:28];
  assign head_rd   = head[27:23];
  assign head_rs1  = head[22:18];
  assign head_rs2  = head[17:13];
  assign head_imm  = head[12:0];

  // RAW check of the head sources against every in-flight rd; x0 never hazards
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_WINDOW; i++) begin
      if (sb_valid[i]) begin
        if ((head_rs1 != 5'd0) && (head_rs1 == sb_rd[i])) hazard = 1'b1;
        if ((head_rs2 != 5'd0) && (head_rs2 == sb_rd[i])) hazard = 1'b1;
      end
    end
  end

  assign not_empty  = (count != '0);
  assign pop        = not_empty && !hazard;
  // Full FIFO still accepts when the head leaves this cycle; held low in reset
  assign in_ready_c = reset && ((count < CW'(FIFO_DEPTH)) || pop);
  assign push       = bus.in_valid && in_ready_c;

  // Storage write (no reset needed: occupancy is tracked by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  // Pointers, occupancy, scoreboard and registered issue slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      issue_valid_q <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      func_q        <= '0;
      addr_q        <= '0;
      for (int i = 0; i < HAZARD_WINDOW; i++) begin
        sb_valid[i] <= 1'b0;
        sb_rd[i]    <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      issue_valid_q <= pop;
      if (pop) begin
        rs1_q  <= head_rs1;
        rs2_q  <= head_rs2;
        rd_q   <= head_rd;
        func_q <= head_func;
        addr_q <= ADDR_BASE + {17'b0, head_imm, 2'b00};
      end else begin
        rs1_q  <= '0;
        rs2_q  <= '0;
        rd_q   <= '0;
        func_q <= '0;
        addr_q <= '0;
      end

      sb_valid[0] <= pop;
      sb_rd[0]    <= pop ? head_rd : 5'd0;
      for (int i = 1; i < HAZARD_WINDOW; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Issues and hazard-caused bubbles; empty-FIFO bubbles are not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued  <= '0;
      perf_bubbles <= '0;
    end else begin
      perf_issued  <= perf_issued + 32'(pop);
      perf_bubbles <= perf_bubbles + 32'(not_empty && hazard);
    end
  end
`endif

  assign bus.in_ready    = in_ready_c;
  assign bus.issue_valid = issue_valid_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.func        = func_q;
  assign bus.addr        = addr_q;
  assign bus.fifo_count  = count;

endmodule

// File: tb/tb_pipe_issue_stage.sv
// Directed bench for pipe_issue_stage: a per-cycle vector table for issue
// latency, back-to-back issue and RAW bubbles, plus hand sequences for the
// full-FIFO stall/drain and mid-operation reset.
module tb_pipe_issue_stage;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_issue_stage_if #(.FIFO_DEPTH(DEPTH)) bus ();

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_bubbles;
`endif

  pipe_issue_stage #(
    .FIFO_DEPTH(DEPTH),
    .HAZARD_WINDOW(3),
    .ADDR_BASE(32'h0000_1000)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ISSUE_PERF_CNT_EN
    .perf_issued(perf_issued),
    .perf_bubbles(perf_bubbles),
`endif
    .bus(bus)
  );

  typedef struct {
    logic        in_valid;
    logic [31:0] instr;
    logic        ev;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  func;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [12:0] imm);
    return {f, rd, rs1, rs2, imm};
  endfunction

  function automatic vec_t row(input logic iv, input logic [31:0] instr, input logic ev,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [3:0] func,
                               input logic [31:0] addr, input logic [2:0] cnt,
                               input logic rdy);
    vec_t v;
    v.in_valid = iv; v.instr = instr; v.ev = ev; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.func = func; v.addr = addr; v.cnt = cnt; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " issue_valid"}, 32'(bus.issue_valid), 32'(v.ev));
    chk({tag, " rs1"},         32'(bus.rs1),         32'(v.rs1));
    chk({tag, " rs2"},         32'(bus.rs2),         32'(v.rs2));
    chk({tag, " rd"},          32'(bus.rd),          32'(v.rd));
    chk({tag, " func"},        32'(bus.func),        32'(v.func));
    chk({tag, " addr"},        bus.addr,             v.addr);
    chk({tag, " fifo_count"},  32'(bus.fifo_count),  32'(v.cnt));
    chk({tag, " in_ready"},    32'(bus.in_ready),    32'(v.rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [16];
  logic [31:0] a_w, b_w, c_w, d_w, e_w;
  logic [3:0]  got [$];
  vec_t        idle_v;

  initial begin
    a_w = mk(4'd0, 5'd10, 5'd5,  5'd6, 13'd0);
    b_w = mk(4'd3, 5'd11, 5'd3,  5'd4, 13'd1);
    c_w = mk(4'd1, 5'd12, 5'd7,  5'd8, 13'd2);
    d_w = mk(4'd2, 5'd13, 5'd12, 5'd0, 13'd3);
    e_w = mk(4'd5, 5'd15, 5'd0,  5'd9, 13'd4);

    tbl[0]  = row(1, a_w,  0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[1]  = row(0, 0,    1, 5, 6, 10, 0, 32'h1000, 0, 1);
    tbl[2]  = row(0, 0,    0, 0, 0, 0, 0, 32'h0,    0, 1);
    tbl[3]  = row(1, a_w,  0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[4]  = row(1, b_w,  1, 5, 6, 10, 0, 32'h1000, 1, 1);
    tbl[5]  = row(0, 0,    1, 3, 4, 11, 3, 32'h1004, 0, 1);
    tbl[6]  = row(1, c_w,  0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[7]  = row(1, d_w,  1, 7, 8, 12, 1, 32'h1008, 1, 1);
    tbl[8]  = row(0, 0,    0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[9]  = row(0, 0,    0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[10] = row(0, 0,    0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[11] = row(0, 0,    1, 12, 0, 13, 2, 32'h100C, 0, 1);
    tbl[12] = row(1, c_w,  0, 0, 0, 0, 0, 32'h0,    1, 1);
    tbl[13] = row(1, e_w,  1, 7, 8, 12, 1, 32'h1008, 1, 1);
    tbl[14] = row(0, 0,    1, 0, 9, 15, 5, 32'h1010, 0, 1);
    tbl[15] = row(0, 0,    0, 0, 0, 0, 0, 32'h0,    0, 1);

    bus.in_valid = 1'b0;
    bus.in_instr = '0;

    // In reset: everything cleared, not ready
    repeat (2) @(posedge clk);
    #1;
    chk_all("in_reset", row(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    reset = 1'b1;

    // Idle after release
    idle_v = row(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("idle%0d", i), idle_v);
    end

    // Vector table: one row per clock
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = tbl[i].in_valid;
      bus.in_instr = tbl[i].instr;
      tick();
      chk_all($sformatf("row%0d", i), tbl[i]);
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();

    // Full FIFO under a RAW stall: dependent chain, func=k, all rd=12
    for (int k = 1; k <= 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = mk(4'(k), 5'd12, (k == 1) ? 5'd0 : 5'd12, 5'd0, 13'(k));
      tick();
      if (k == 5) begin
        chk("full_pop fifo_count", 32'(bus.fifo_count), 32'd4);
        chk("full_pop in_ready",   32'(bus.in_ready),   32'd1);
      end
    end
    chk("full fifo_count", 32'(bus.fifo_count), 32'd4);
    chk("full in_ready",   32'(bus.in_ready),   32'd0);
    bus.in_instr = mk(4'd7, 5'd12, 5'd12, 5'd0, 13'd7);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("reject%0d fifo_count", k), 32'(bus.fifo_count), 32'd4);
      chk($sformatf("reject%0d in_ready", k),   32'(bus.in_ready),   32'd0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("unstall fifo_count", 32'(bus.fifo_count), 32'd4);
    chk("unstall in_ready",   32'(bus.in_ready),   32'd1);
    got.delete();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.issue_valid) got.push_back(bus.func);
    end
    chk("drain issued", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain order%0d func", i),
          (i < got.size()) ? 32'(got[i]) : 32'hF, 32'(i + 3));
    chk("drain fifo_count", 32'(bus.fifo_count), 32'd0);

    // Reset with three words buffered behind a hazard
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = mk(4'(8 + k), 5'd12, (k == 0) ? 5'd0 : 5'd12, 5'd0, 13'(k));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("prereset fifo_count", 32'(bus.fifo_count), 32'd3);
    reset = 1'b0;
    #1;
    chk_all("async_reset", row(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_issued after reset",  perf_issued,  32'd0);
    chk("perf_bubbles after reset", perf_bubbles, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("post_reset%0d", i), idle_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_issue_stage.md
Name: pipe_issue_stage

Overview:
Upstream neighbour of the pipeline processor. It accepts 32-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. Each word is decoded into the rs1/rs2/rd/func/addr fields the pipeline consumes. A scoreboard of in-flight destination registers inserts bubbles to hold back read-after-write hazards; the processor has no interlock of its own.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries; power of two, 2..16
HAZARD_WINDOW, 3, number of cycles an issued rd stays unreadable (processor write-back latency)
ADDR_BASE, 32'h0000_1000, base added to the scaled immediate to form addr

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  instruction word valid
in_ready  output  1  FIFO can accept a word this cycle
in_instr  input  32  instruction: [31:28] func, [27:23] rd, [22:18] rs1, [17:13] rs2, [12:0] imm
issue_valid  output  1  decoded fields below are a real instruction (0 = bubble)
rs1  output  5  source register 1 to processor
rs2  output  5  source register 2 to processor
rd  output  5  destination register to processor
func  output  4  ALU function to processor
addr  output  32  memory address to processor
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset low, async): FIFO empty, pointers 0, scoreboard cleared, issue_valid=0, rs1/rs2/rd/func=0, addr=0, fifo_count=0. in_ready=0 while reset is asserted; in_ready=1 from the first cycle after release.
- Push occurs when in_valid && in_ready. in_ready = (fifo_count < FIFO_DEPTH). A push is accepted when full only if a pop happens in the same cycle; in_ready therefore stays 1 when full with a pop in progress.
- Decode is combinational from the FIFO head:
  - addr = ADDR_BASE + {17'b0, imm, 2'b00}, modulo 2^32.
  - All outputs are registered, so issue latency is 1 cycle from the cycle the head becomes eligible.
- Scoreboard: a shift register of HAZARD_WINDOW entries, each {valid, rd5}. It shifts every cycle. Entry 0 loads {1, rd} on an issue and {0, 0} on a bubble.
- Hazard: the head (rs1 != 0 and matches any valid scoreboard rd) or (rs2 != 0 and matches any valid scoreboard rd). Register 0 never hazards. rd==0 is still written to the scoreboard but never matches.
- Per-cycle outcome:
  - FIFO non-empty and no hazard: pop; next cycle issue_valid=1 with decoded fields.
  - Hazard or FIFO empty: next cycle issue_valid=0 and rs1/rs2/rd/func/addr driven to 0 (bubble); no pop.
- Simultaneous push and pop: count is unchanged; the pointers advance and wrap modulo FIFO_DEPTH.
- Push into an empty FIFO: the word becomes the head the next cycle. There is no same-cycle bypass, so minimum in_valid-to-issue_valid latency is 2 cycles.
- Reset mid-operation: buffered words and the scoreboard are discarded. The first output after release is a bubble.
- Steady-state throughput is 1 instruction/cycle when there are no hazards. A dependent back-to-back pair is separated by exactly HAZARD_WINDOW bubbles.

Optional Feature:
ISSUE_PERF_CNT_EN
- Defined: adds outputs perf_issued (32) and perf_bubbles (32).
  - perf_issued increments on each issue_valid=1 cycle.
  - perf_bubbles increments on each bubble cycle caused by a hazard; empty-FIFO bubbles are not counted.
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> issue_valid=0, all fields 0, in_ready=1, fifo_count=0 for 10 cycles.
- Push func=0, rd=10, rs1=5, rs2=6, imm=0 -> exactly 2 cycles after the push, issue_valid=1 with rs1=5, rs2=6, rd=10, func=0000, addr=32'h1000.
- Push independent words (rd=10/rs 5,6), then (rd=11/rs 3,4, imm=1) -> issued on consecutive cycles; second addr=32'h1004; no bubble between them.
- Push rd=12 from rs 7,8, then rs1=12 -> exactly 3 bubbles between the two issue_valid pulses. With rs1=0 instead -> no bubbles.
- Hold off the pop with a hazard and push 4 words -> fifo_count=4, in_ready=0, and the 5th word is not accepted. When the hazard clears, the words drain in FIFO order.
- Assert reset with 3 words buffered -> immediate clear (issue_valid=0, fifo_count=0). After release, no stale instruction is issued. With ISSUE_PERF_CNT_EN defined, both counters read 0 after the reset.
